// File: rtl/frame_buffer_pkg.sv
// Shared helpers for the frame buffer ownership tracker: index width and
// the small modulo / saturating arithmetic used by the ring bookkeeping.
package frame_buffer_pkg;

  // Index width with a floor of one bit so a 2-buffer ring still has an index.
  function automatic int idxw(input int buffers);
    return (buffers <= 2) ? 1 : $clog2(buffers);
  endfunction

  function automatic int ring_add(input int index, input int offset, input int buffers);
    return (index + offset) % buffers;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int width);
    longint max_v;
    max_v = (longint'(1) << width) - 1;
    return ((a + b) > max_v) ? max_v : (a + b);
  endfunction

endpackage

// File: rtl/frame_buffer_manager.sv
// Tracks ownership of a ring of frame buffers between loader and display driver,
// with dwell, skip-to-newest, immediate flip, hold and drop/overrun accounting.
module frame_buffer_manager
  import frame_buffer_pkg::*;
#(
  parameter int BUFFERS    = 2,
  parameter int MIN_FRAMES = 1,
  parameter int CNT_WIDTH  = 8,
  localparam int IDXW      = idxw(BUFFERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_complete,
  input  logic                 loaded,
  input  logic                 hold,
  input  logic                 skip_mode,
  input  logic                 immediate,
  output logic                 ready,
  output logic [IDXW-1:0]      wbuf,
  output logic [IDXW-1:0]      rbuf,
  output logic [IDXW:0]        pending,
  output logic                 flip,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 overrun
);

  localparam int PW  = IDXW + 1;
  localparam int SHW = $clog2(MIN_FRAMES + 1);

  logic [IDXW-1:0]      rbuf_reg, rbuf_next;
  logic [IDXW-1:0]      wbuf_reg, wbuf_next;
  logic [PW-1:0]        pending_reg, pending_next;
  logic                 ready_reg, ready_next;
  logic                 flip_reg;
  logic [CNT_WIDTH-1:0] drop_reg, drop_next;
  logic                 overrun_reg, overrun_next;
  logic [SHW-1:0]       shown_reg, shown_next;

  logic load_ok;
  logic flip_ok;
  int   advance;
  int   pending_calc;

  always_comb begin
    load_ok = loaded && ready_reg;
    // Dwell test uses the pre-update count so the completing frame itself counts.
    flip_ok = (pending_reg != '0) && !hold &&
              (immediate || (frame_complete && ((int'(shown_reg) + 1) >= MIN_FRAMES)));
    advance = skip_mode ? int'(pending_reg) : 1;

    rbuf_next    = rbuf_reg;
    pending_calc = int'(pending_reg);
    drop_next    = drop_reg;
    shown_next   = shown_reg;
    overrun_next = overrun_reg | (loaded & ~ready_reg);

    if (flip_ok) begin
      rbuf_next    = IDXW'(ring_add(int'(rbuf_reg), advance, BUFFERS));
      pending_calc = pending_calc - advance;
      shown_next   = '0;
      if (skip_mode) begin
        drop_next = CNT_WIDTH'(sat_add(longint'(drop_reg), longint'(advance - 1), CNT_WIDTH));
      end
    end else if (frame_complete && (int'(shown_reg) < MIN_FRAMES)) begin
      shown_next = shown_reg + SHW'(1);
    end

    // A load landing with a flip is never part of the skipped set.
    if (load_ok) begin
      pending_calc = pending_calc + 1;
    end

    pending_next = PW'(pending_calc);
    wbuf_next    = IDXW'(ring_add(int'(rbuf_next), pending_calc + 1, BUFFERS));
    ready_next   = (pending_calc < (BUFFERS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbuf_reg    <= '0;
      wbuf_reg    <= IDXW'(1);
      pending_reg <= '0;
      ready_reg   <= 1'b1;
      flip_reg    <= 1'b0;
      drop_reg    <= '0;
      overrun_reg <= 1'b0;
      shown_reg   <= '0;
    end else begin
      rbuf_reg    <= rbuf_next;
      wbuf_reg    <= wbuf_next;
      pending_reg <= pending_next;
      ready_reg   <= ready_next;
      flip_reg    <= flip_ok;
      drop_reg    <= drop_next;
      overrun_reg <= overrun_next;
      shown_reg   <= shown_next;
    end
  end

  assign rbuf       = rbuf_reg;
  assign wbuf       = wbuf_reg;
  assign pending    = pending_reg;
  assign ready      = ready_reg;
  assign flip       = flip_reg;
  assign drop_count = drop_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager across four parameter sets; expected
// states are queued as each step is driven and checked after the clock edge.
module tb_frame_buffer_manager;

  typedef struct {
    int rbuf;
    int pending;
    int wbuf;
    int ready;
    int flip;
    int drop;
    int overrun;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rsts = 4'hF;
  logic       frame_complete = 1'b0;
  logic       loaded = 1'b0;
  logic       hold = 1'b0;
  logic       skip_mode = 1'b0;
  logic       immediate = 1'b0;
  int         sel = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  // u2: BUFFERS=2, MIN_FRAMES=1
  logic       rdy2, fl2, ov2;
  logic [0:0] wb2, rb2;
  logic [1:0] pd2;
  logic [7:0] dc2;
  // u3: BUFFERS=3, MIN_FRAMES=3
  logic       rdy3, fl3, ov3;
  logic [1:0] wb3, rb3;
  logic [2:0] pd3;
  logic [7:0] dc3;
  // u3s: BUFFERS=3, MIN_FRAMES=1
  logic       rdy3s, fl3s, ov3s;
  logic [1:0] wb3s, rb3s;
  logic [2:0] pd3s;
  logic [7:0] dc3s;
  // u4: BUFFERS=4, MIN_FRAMES=1, CNT_WIDTH=2
  logic       rdy4, fl4, ov4;
  logic [1:0] wb4, rb4;
  logic [2:0] pd4;
  logic [1:0] dc4;

  frame_buffer_manager #(.BUFFERS(2), .MIN_FRAMES(1), .CNT_WIDTH(8)) u2 (
    .clk(clk), .rst(rsts[0]), .frame_complete(frame_complete), .loaded(loaded),
    .hold(hold), .skip_mode(skip_mode), .immediate(immediate), .ready(rdy2),
    .wbuf(wb2), .rbuf(rb2), .pending(pd2), .flip(fl2), .drop_count(dc2), .overrun(ov2));

  frame_buffer_manager #(.BUFFERS(3), .MIN_FRAMES(3), .CNT_WIDTH(8)) u3 (
    .clk(clk), .rst(rsts[1]), .frame_complete(frame_complete), .loaded(loaded),
    .hold(hold), .skip_mode(skip_mode), .immediate(immediate), .ready(rdy3),
    .wbuf(wb3), .rbuf(rb3), .pending(pd3), .flip(fl3), .drop_count(dc3), .overrun(ov3));

  frame_buffer_manager #(.BUFFERS(3), .MIN_FRAMES(1), .CNT_WIDTH(8)) u3s (
    .clk(clk), .rst(rsts[2]), .frame_complete(frame_complete), .loaded(loaded),
    .hold(hold), .skip_mode(skip_mode), .immediate(immediate), .ready(rdy3s),
    .wbuf(wb3s), .rbuf(rb3s), .pending(pd3s), .flip(fl3s), .drop_count(dc3s), .overrun(ov3s));

  frame_buffer_manager #(.BUFFERS(4), .MIN_FRAMES(1), .CNT_WIDTH(2)) u4 (
    .clk(clk), .rst(rsts[3]), .frame_complete(frame_complete), .loaded(loaded),
    .hold(hold), .skip_mode(skip_mode), .immediate(immediate), .ready(rdy4),
    .wbuf(wb4), .rbuf(rb4), .pending(pd4), .flip(fl4), .drop_count(dc4), .overrun(ov4));

  int o_rbuf, o_pend, o_wbuf, o_rdy, o_flip, o_drop, o_ovr;

  always_comb begin
    o_rbuf = 0; o_pend = 0; o_wbuf = 0; o_rdy = 0; o_flip = 0; o_drop = 0; o_ovr = 0;
    case (sel)
      0: begin
        o_rbuf = int'(rb2); o_pend = int'(pd2); o_wbuf = int'(wb2); o_rdy = int'(rdy2);
        o_flip = int'(fl2); o_drop = int'(dc2); o_ovr = int'(ov2);
      end
      1: begin
        o_rbuf = int'(rb3); o_pend = int'(pd3); o_wbuf = int'(wb3); o_rdy = int'(rdy3);
        o_flip = int'(fl3); o_drop = int'(dc3); o_ovr = int'(ov3);
      end
      2: begin
        o_rbuf = int'(rb3s); o_pend = int'(pd3s); o_wbuf = int'(wb3s); o_rdy = int'(rdy3s);
        o_flip = int'(fl3s); o_drop = int'(dc3s); o_ovr = int'(ov3s);
      end
      default: begin
        o_rbuf = int'(rb4); o_pend = int'(pd4); o_wbuf = int'(wb4); o_rdy = int'(rdy4);
        o_flip = int'(fl4); o_drop = int'(dc4); o_ovr = int'(ov4);
      end
    endcase
  end

  task automatic cmp(input string tag, input string field, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    $display("txn %-12s dut=%0d rbuf=%0d pending=%0d wbuf=%0d ready=%0d flip=%0d drop=%0d overrun=%0d",
             tag, sel, o_rbuf, o_pend, o_wbuf, o_rdy, o_flip, o_drop, o_ovr);
    cmp(tag, "rbuf", o_rbuf, e.rbuf);
    cmp(tag, "pending", o_pend, e.pending);
    cmp(tag, "wbuf", o_wbuf, e.wbuf);
    cmp(tag, "ready", o_rdy, e.ready);
    cmp(tag, "flip", o_flip, e.flip);
    cmp(tag, "drop", o_drop, e.drop);
    cmp(tag, "overrun", o_ovr, e.overrun);
  endtask

  task automatic push(input int r, input int p, input int w, input int rd,
                      input int f, input int d, input int ov);
    exp_t e;
    e.rbuf = r; e.pending = p; e.wbuf = w; e.ready = rd;
    e.flip = f; e.drop = d; e.overrun = ov;
    sb.push_back(e);
  endtask

  // One clock of stimulus; the expected state is what the DUT shows after the edge.
  task automatic step(input string tag, input logic ld, input logic fc,
                      input int r, input int p, input int w, input int rd,
                      input int f, input int d, input int ov);
    @(negedge clk);
    loaded = ld;
    frame_complete = fc;
    push(r, p, w, rd, f, d, ov);
    @(posedge clk);
    #1;
    loaded = 1'b0;
    frame_complete = 1'b0;
    check_pop(tag);
  endtask

  task automatic select_dut(input int s, input string tag);
    @(negedge clk);
    rsts = 4'hF;
    sel = s;
    @(negedge clk);
    rsts[s] = 1'b0;
    step(tag, 1'b0, 1'b0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  initial begin
    // Double buffer: basic load / flip handshake
    select_dut(0, "a_reset");
    step("a_load",  1'b1, 1'b0, 0, 1, 0, 0, 0, 0, 0);
    step("a_flip",  1'b0, 1'b1, 1, 0, 0, 1, 1, 0, 0);
    step("a_idle",  1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0);

    // Triple buffer with three-frame dwell
    select_dut(1, "b_reset");
    step("b_load",  1'b1, 1'b0, 0, 1, 2, 1, 0, 0, 0);
    step("b_fc1",   1'b0, 1'b1, 0, 1, 2, 1, 0, 0, 0);
    step("b_fc2",   1'b0, 1'b1, 0, 1, 2, 1, 0, 0, 0);
    step("b_fc3",   1'b0, 1'b1, 1, 0, 2, 1, 1, 0, 0);
    step("b_load2", 1'b1, 1'b0, 1, 1, 0, 1, 0, 0, 0);
    step("b_fc4",   1'b0, 1'b1, 1, 1, 0, 1, 0, 0, 0);

    // Quad buffer skip mode, overrun, drop saturation at two bits
    select_dut(3, "c_reset");
    skip_mode = 1'b1;
    step("c_load1", 1'b1, 1'b0, 0, 1, 2, 1, 0, 0, 0);
    step("c_load2", 1'b1, 1'b0, 0, 2, 3, 1, 0, 0, 0);
    step("c_load3", 1'b1, 1'b0, 0, 3, 0, 0, 0, 0, 0);
    step("c_over",  1'b1, 1'b0, 0, 3, 0, 0, 0, 0, 1);
    step("c_skip1", 1'b0, 1'b1, 3, 0, 0, 1, 1, 2, 1);
    step("c_load4", 1'b1, 1'b0, 3, 1, 1, 1, 0, 2, 1);
    step("c_load5", 1'b1, 1'b0, 3, 2, 2, 1, 0, 2, 1);
    step("c_load6", 1'b1, 1'b0, 3, 3, 3, 0, 0, 2, 1);
    step("c_skip2", 1'b0, 1'b1, 2, 0, 3, 1, 1, 3, 1);
    step("c_load7", 1'b1, 1'b0, 2, 1, 0, 1, 0, 3, 1);
    step("c_load8", 1'b1, 1'b0, 2, 2, 1, 1, 0, 3, 1);
    step("c_load9", 1'b1, 1'b0, 2, 3, 2, 0, 0, 3, 1);
    step("c_skip3", 1'b0, 1'b1, 1, 0, 2, 1, 1, 3, 1);
    skip_mode = 1'b0;

    // Triple buffer: load coinciding with flip, then async reset mid-queue
    select_dut(2, "d_reset");
    step("d_load",  1'b1, 1'b0, 0, 1, 2, 1, 0, 0, 0);
    step("d_both",  1'b1, 1'b1, 1, 1, 0, 1, 1, 0, 0);
    step("d_load2", 1'b1, 1'b0, 1, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rsts[2] = 1'b1;
    push(0, 0, 1, 1, 0, 0, 0);
    #1;
    check_pop("d_async");

    // Immediate mode gated by hold
    hold = 1'b1;
    immediate = 1'b1;
    select_dut(0, "e_reset");
    step("e_load",  1'b1, 1'b0, 0, 1, 0, 0, 0, 0, 0);
    step("e_held",  1'b0, 1'b0, 0, 1, 0, 0, 0, 0, 0);
    hold = 1'b0;
    step("e_rel",   1'b0, 1'b0, 1, 0, 0, 1, 1, 0, 0);
    step("e_idle",  1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0);
    immediate = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
